// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register carrying operands, immediate, PC+4,
//            register addresses and WB/MEM/EX control. Adds a valid bit,
//            external hold, branch flush, load-use hazard detection with
//            single-bubble insertion, and a saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               stall_ext,
  input  logic               flush,
  input  logic [DATA_W-1:0]  readData1,
  input  logic [DATA_W-1:0]  readData2,
  input  logic [DATA_W-1:0]  signExtend,
  input  logic [DATA_W-1:0]  pcPlus4,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic               regWrite,
  input  logic               memToReg,
  input  logic               branch,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic               regDest,
  input  logic               aluSrc,
  input  logic [ALUOP_W-1:0] aluOp,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_readData1,
  output logic [DATA_W-1:0]  out_readData2,
  output logic [DATA_W-1:0]  out_signExtend,
  output logic [DATA_W-1:0]  out_pcPlus4,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic               out_regWrite,
  output logic               out_memToReg,
  output logic               out_branch,
  output logic               out_memRead,
  output logic               out_memWrite,
  output logic               out_regDest,
  output logic               out_aluSrc,
  output logic [ALUOP_W-1:0] out_aluOp,
  output logic               hazard_stall,
  output logic [CNT_W-1:0]   bubble_count
);

  logic do_bubble;
  logic do_load;
  logic cnt_full;

  // Load-use detection: a valid load in EX whose destination (non-$0) is a
  // source of the instruction now in decode.
  always_comb begin
    hazard_stall = out_valid & out_memRead & in_valid &
                   (out_rt != '0) & ((out_rt == rs) | (out_rt == rt));
  end

  // Action select: flush beats hold, hold beats hazard bubble, else load.
  always_comb begin
    do_bubble = flush | (~stall_ext & hazard_stall);
    do_load   = ~flush & ~stall_ext & ~hazard_stall;
    cnt_full  = (bubble_count == {CNT_W{1'b1}});
  end

  // Data and address fields: captured only on a load, held otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_readData1  <= '0;
      out_readData2  <= '0;
      out_signExtend <= '0;
      out_pcPlus4    <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
    end else if (do_load) begin
      out_readData1  <= readData1;
      out_readData2  <= readData2;
      out_signExtend <= signExtend;
      out_pcPlus4    <= pcPlus4;
      out_rs         <= rs;
      out_rt         <= rt;
      out_rd         <= rd;
    end
  end

  // Valid bit and control group: cleared on a bubble, gated by in_valid on a
  // load so an invalid slot never carries live control.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_regWrite <= 1'b0;
      out_memToReg <= 1'b0;
      out_branch   <= 1'b0;
      out_memRead  <= 1'b0;
      out_memWrite <= 1'b0;
      out_regDest  <= 1'b0;
      out_aluSrc   <= 1'b0;
      out_aluOp    <= '0;
    end else if (do_bubble) begin
      out_valid    <= 1'b0;
      out_regWrite <= 1'b0;
      out_memToReg <= 1'b0;
      out_branch   <= 1'b0;
      out_memRead  <= 1'b0;
      out_memWrite <= 1'b0;
      out_regDest  <= 1'b0;
      out_aluSrc   <= 1'b0;
      out_aluOp    <= '0;
    end else if (do_load) begin
      out_valid    <= in_valid;
      out_regWrite <= in_valid & regWrite;
      out_memToReg <= in_valid & memToReg;
      out_branch   <= in_valid & branch;
      out_memRead  <= in_valid & memRead;
      out_memWrite <= in_valid & memWrite;
      out_regDest  <= in_valid & regDest;
      out_aluSrc   <= in_valid & aluSrc;
      out_aluOp    <= in_valid ? aluOp : '0;
    end
  end

  // Saturating count of inserted bubbles (flush or hazard), never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count <= '0;
    end else if (do_bubble && !cnt_full) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed, table-driven bench for id_ex_stage (CNT_W=2 so the
//            bubble counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, stall_ext = 1'b0, flush = 1'b0;
  logic [31:0] readData1 = '0, readData2 = '0, signExtend = '0, pcPlus4 = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        regWrite = 1'b0, memToReg = 1'b0, branch = 1'b0, memRead = 1'b0;
  logic        memWrite = 1'b0, regDest = 1'b0, aluSrc = 1'b0;
  logic [1:0]  aluOp = '0;

  logic        out_valid;
  logic [31:0] out_readData1, out_readData2, out_signExtend, out_pcPlus4;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic        out_regWrite, out_memToReg, out_branch, out_memRead;
  logic        out_memWrite, out_regDest, out_aluSrc;
  logic [1:0]  out_aluOp;
  logic        hazard_stall;
  logic [1:0]  bubble_count;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .ALUOP_W(2), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .stall_ext(stall_ext), .flush(flush),
    .readData1(readData1), .readData2(readData2),
    .signExtend(signExtend), .pcPlus4(pcPlus4),
    .rs(rs), .rt(rt), .rd(rd),
    .regWrite(regWrite), .memToReg(memToReg), .branch(branch),
    .memRead(memRead), .memWrite(memWrite), .regDest(regDest),
    .aluSrc(aluSrc), .aluOp(aluOp),
    .out_valid(out_valid),
    .out_readData1(out_readData1), .out_readData2(out_readData2),
    .out_signExtend(out_signExtend), .out_pcPlus4(out_pcPlus4),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_regWrite(out_regWrite), .out_memToReg(out_memToReg),
    .out_branch(out_branch), .out_memRead(out_memRead),
    .out_memWrite(out_memWrite), .out_regDest(out_regDest),
    .out_aluSrc(out_aluSrc), .out_aluOp(out_aluOp),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v, fl, st;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d;
    logic        mr, rw, mw;
    logic [1:0]  alu;
    logic        hz, ov;
    logic [4:0]  ord, ort;
    logic [31:0] od;
    logic        omr, orw, omw;
    logic [1:0]  oal;
    logic [1:0]  cnt;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vec [NVEC];

  int checks = 0;
  int failures = 0;
  int cur_step = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, cur_step, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid   = t.v;
    flush      = t.fl;
    stall_ext  = t.st;
    rs         = t.rs;
    rt         = t.rt;
    rd         = t.rd;
    readData1  = t.d;
    readData2  = t.d ^ 32'hFFFF0000;
    signExtend = t.d + 32'd1;
    pcPlus4    = t.d + 32'd4;
    memRead    = t.mr;
    regWrite   = t.rw;
    memToReg   = t.rw;
    branch     = t.rw;
    regDest    = t.rw;
    aluSrc     = t.rw;
    memWrite   = t.mw;
    aluOp      = t.alu;
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rd1"}, out_readData1, 32'd0);
    chk({tag, "_rt"}, {27'd0, out_rt}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, out_regWrite, out_memToReg, out_branch, out_memRead,
                         out_memWrite, out_regDest, out_aluOp}, 32'd0);
    chk({tag, "_cnt"}, {30'd0, bubble_count}, 32'd0);
    chk({tag, "_hz"}, {31'd0, hazard_stall}, 32'd0);
  endtask

  vec_t t;

  initial begin
    // fields: v fl st rs rt rd d mr rw mw alu | hz ov ord ort od omr orw omw oal cnt
    vec[0]  = '{1'b1,1'b0,1'b0, 5'd1,5'd2,5'd7,  32'h1234, 1'b0,1'b1,1'b0, 2'd2,
                1'b0,1'b1, 5'd7, 5'd2, 32'h1234, 1'b0,1'b1,1'b0, 2'd2, 2'd0};
    vec[1]  = '{1'b1,1'b0,1'b0, 5'd3,5'd5,5'd0,  32'h10,   1'b1,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd0, 5'd5, 32'h10,   1'b1,1'b1,1'b0, 2'd0, 2'd0};
    vec[2]  = '{1'b1,1'b0,1'b0, 5'd5,5'd6,5'd8,  32'h20,   1'b0,1'b1,1'b0, 2'd2,
                1'b1,1'b0, 5'd0, 5'd5, 32'h10,   1'b0,1'b0,1'b0, 2'd0, 2'd1};
    vec[3]  = '{1'b1,1'b0,1'b0, 5'd5,5'd6,5'd8,  32'h20,   1'b0,1'b1,1'b0, 2'd2,
                1'b0,1'b1, 5'd8, 5'd6, 32'h20,   1'b0,1'b1,1'b0, 2'd2, 2'd1};
    vec[4]  = '{1'b1,1'b0,1'b0, 5'd0,5'd0,5'd0,  32'h30,   1'b1,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd0, 5'd0, 32'h30,   1'b1,1'b1,1'b0, 2'd0, 2'd1};
    vec[5]  = '{1'b1,1'b0,1'b0, 5'd0,5'd0,5'd9,  32'h40,   1'b0,1'b1,1'b0, 2'd1,
                1'b0,1'b1, 5'd9, 5'd0, 32'h40,   1'b0,1'b1,1'b0, 2'd1, 2'd1};
    vec[6]  = '{1'b0,1'b0,1'b0, 5'd1,5'd2,5'd3,  32'h50,   1'b0,1'b1,1'b1, 2'd3,
                1'b0,1'b0, 5'd3, 5'd2, 32'h50,   1'b0,1'b0,1'b0, 2'd0, 2'd1};
    vec[7]  = '{1'b1,1'b0,1'b0, 5'd1,5'd4,5'd10, 32'h60,   1'b0,1'b0,1'b1, 2'd0,
                1'b0,1'b1, 5'd10,5'd4, 32'h60,   1'b0,1'b0,1'b1, 2'd0, 2'd1};
    vec[8]  = '{1'b1,1'b1,1'b1, 5'd1,5'd4,5'd11, 32'h70,   1'b0,1'b0,1'b1, 2'd0,
                1'b0,1'b0, 5'd10,5'd4, 32'h60,   1'b0,1'b0,1'b0, 2'd0, 2'd2};
    vec[9]  = '{1'b1,1'b0,1'b0, 5'd2,5'd5,5'd12, 32'h80,   1'b0,1'b1,1'b0, 2'd2,
                1'b0,1'b1, 5'd12,5'd5, 32'h80,   1'b0,1'b1,1'b0, 2'd2, 2'd2};
    for (int k = 10; k <= 12; k++)
      vec[k] = '{1'b1,1'b0,1'b1, 5'd1,5'd1,5'd13, 32'h90,  1'b1,1'b0,1'b0, 2'd0,
                 1'b0,1'b1, 5'd12,5'd5, 32'h80,  1'b0,1'b1,1'b0, 2'd2, 2'd2};
    vec[13] = '{1'b1,1'b0,1'b0, 5'd1,5'd7,5'd0,  32'hA0,   1'b1,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd0, 5'd7, 32'hA0,   1'b1,1'b1,1'b0, 2'd0, 2'd2};
    vec[14] = '{1'b1,1'b0,1'b1, 5'd2,5'd7,5'd14, 32'hB0,   1'b0,1'b1,1'b0, 2'd0,
                1'b1,1'b1, 5'd0, 5'd7, 32'hA0,   1'b1,1'b1,1'b0, 2'd0, 2'd2};
    vec[15] = '{1'b1,1'b1,1'b0, 5'd2,5'd7,5'd14, 32'hB0,   1'b0,1'b1,1'b0, 2'd0,
                1'b1,1'b0, 5'd0, 5'd7, 32'hA0,   1'b0,1'b0,1'b0, 2'd0, 2'd3};
    vec[16] = '{1'b1,1'b0,1'b0, 5'd1,5'd2,5'd15, 32'hC0,   1'b0,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd15,5'd2, 32'hC0,   1'b0,1'b1,1'b0, 2'd0, 2'd3};
    vec[17] = '{1'b1,1'b0,1'b0, 5'd0,5'd3,5'd0,  32'hD0,   1'b1,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd0, 5'd3, 32'hD0,   1'b1,1'b1,1'b0, 2'd0, 2'd3};
    vec[18] = '{1'b1,1'b0,1'b0, 5'd3,5'd0,5'd16, 32'hE0,   1'b0,1'b1,1'b0, 2'd0,
                1'b1,1'b0, 5'd0, 5'd3, 32'hD0,   1'b0,1'b0,1'b0, 2'd0, 2'd3};
    vec[19] = '{1'b1,1'b0,1'b0, 5'd3,5'd0,5'd16, 32'hE0,   1'b0,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd16,5'd0, 32'hE0,   1'b0,1'b1,1'b0, 2'd0, 2'd3};
    vec[20] = '{1'b1,1'b0,1'b0, 5'd0,5'd9,5'd0,  32'hF0,   1'b1,1'b1,1'b0, 2'd0,
                1'b0,1'b1, 5'd0, 5'd9, 32'hF0,   1'b1,1'b1,1'b0, 2'd0, 2'd3};
    vec[21] = '{1'b1,1'b0,1'b0, 5'd4,5'd9,5'd17, 32'h100,  1'b0,1'b1,1'b0, 2'd0,
                1'b1,1'b0, 5'd0, 5'd9, 32'hF0,   1'b0,1'b0,1'b0, 2'd0, 2'd3};

    // Reset held with busy inputs: everything stays zero.
    t = '{1'b1,1'b0,1'b0, 5'd3,5'd3,5'd6, 32'hDEAD, 1'b1,1'b1,1'b0, 2'd1,
          1'b0,1'b0, 5'd0,5'd0, 32'h0, 1'b0,1'b0,1'b0, 2'd0, 2'd0};
    drive(t);
    repeat (2) @(posedge clock);
    #1 chk_reset_zero("rst_hold");

    // Release, load a lw with rt=3 (decode rs=rt=3 would hazard), then an
    // asynchronous reset between edges must clear it at once.
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1 chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_hz", {31'd0, hazard_stall}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_zero("rst_async");
    @(negedge clock) reset_n = 1'b1;

    // Table-driven sequence.
    for (int i = 0; i < NVEC; i++) begin
      cur_step = i;
      @(negedge clock);
      drive(vec[i]);
      #1 chk("hazard", {31'd0, hazard_stall}, {31'd0, vec[i].hz});
      @(posedge clock);
      #1;
      chk("valid",   {31'd0, out_valid},    {31'd0, vec[i].ov});
      chk("rd",      {27'd0, out_rd},       {27'd0, vec[i].ord});
      chk("rt",      {27'd0, out_rt},       {27'd0, vec[i].ort});
      chk("rdata1",  out_readData1,         vec[i].od);
      chk("rdata2",  out_readData2,         vec[i].od ^ 32'hFFFF0000);
      chk("sext",    out_signExtend,        vec[i].od + 32'd1);
      chk("pc4",     out_pcPlus4,           vec[i].od + 32'd4);
      chk("memRead", {31'd0, out_memRead},  {31'd0, vec[i].omr});
      chk("regWrite",{31'd0, out_regWrite}, {31'd0, vec[i].orw});
      chk("memWrite",{31'd0, out_memWrite}, {31'd0, vec[i].omw});
      chk("ctrl4",   {28'd0, out_memToReg, out_branch, out_regDest, out_aluSrc},
                     {28'd0, {4{vec[i].orw}}});
      chk("aluOp",   {30'd0, out_aluOp},    {30'd0, vec[i].oal});
      chk("count",   {30'd0, bubble_count}, {30'd0, vec[i].cnt});
    end

    // Mid-operation reset discards a live load and the saturated counter.
    cur_step = 100;
    @(negedge clock);
    t = '{1'b1,1'b0,1'b0, 5'd1,5'd2,5'd20, 32'h5555, 1'b1,1'b1,1'b0, 2'd2,
          1'b0,1'b0, 5'd0,5'd0, 32'h0, 1'b0,1'b0,1'b0, 2'd0, 2'd0};
    drive(t);
    @(posedge clock);
    #1 chk("pre_rst2_rd", {27'd0, out_rd}, 32'd20);
    #2 reset_n = 1'b0;
    #1 chk_reset_zero("rst_mid");
    chk("rst_mid_rd", {27'd0, out_rd}, 32'd0);
    @(negedge clock) reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog step=%0d actual=timeout expected=finish", cur_step);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline register for the MIPS datapath. It sits between decode and execute and carries operands, immediate, PC+4, register addresses and the WB/MEM/EX control groups. Unlike a plain capture register it adds a valid bit, external stall (hold), branch flush, and built-in load-use hazard detection that inserts one bubble. A saturating counter records how many bubbles were inserted.

## Interface
- DATA_W, 32, width of readData1/readData2/signExtend/pcPlus4
- REG_W, 5, register-address width
- ALUOP_W, 2, aluOp width
- CNT_W, 16, bubble_count width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode stage holds a real instruction
- stall_ext  in  1  downstream hold; freeze all registers
- flush  in  1  branch taken; kill instruction entering EX
- readData1, readData2, signExtend, pcPlus4  in  DATA_W  decode data fields
- rs, rt, rd  in  REG_W  decode register addresses
- regWrite, memToReg, branch, memRead, memWrite, regDest, aluSrc  in  1  decode control bits
- aluOp  in  ALUOP_W  ALU operation class
- out_valid  out  1  EX stage holds a real instruction
- out_readData1, out_readData2, out_signExtend, out_pcPlus4  out  DATA_W  registered data
- out_rs, out_rt, out_rd  out  REG_W  registered addresses
- out_regWrite, out_memToReg, out_branch, out_memRead, out_memWrite, out_regDest, out_aluSrc  out  1  registered control
- out_aluOp  out  ALUOP_W  registered ALU op
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_count  out  CNT_W  saturating count of bubbles inserted

## Operation
- Hazard: hazard_stall = out_valid & out_memRead & in_valid & (out_rt != 0) & (out_rt == rs | out_rt == rt). Purely combinational from registers and inputs, no reset dependence beyond registers.
- Per rising edge, priority flush > stall_ext > hazard_stall > load:
  - flush: out_valid<=0; all control outputs <=0 (aluOp<=0); data/address outputs hold; bubble_count increments.
  - stall_ext: every register holds, including out_valid and bubble_count.
  - hazard_stall: bubble. out_valid<=0; controls <=0; data/address hold; bubble_count increments. Upstream is holding the instruction, so the next cycle re-presents it.
  - load: all data/address fields captured; out_valid<=in_valid; controls captured if in_valid, else forced 0.
- Invariant: out_valid==0 implies every control output ==0, so downstream never writes memory or registers on a bubble.
- bubble_count saturates at 2^CNT_W-1 and never wraps. A load of in_valid=0 does not count as a bubble.
- Register $0 never triggers a hazard.

## Timing
- Reset (reset_n low, async, immediate): every output register is 0. out_valid=0, bubble_count=0, so hazard_stall=0. Release is sampled at the next rising edge.
- Reset mid-operation discards the in-flight instruction without waiting for the clock.
- Latency is one cycle from input to out_* in the load case.
- A load-use pair costs exactly one bubble cycle. On the cycle after the bubble, out_memRead=0, hazard_stall drops and the dependent instruction loads.
- flush together with hazard_stall: the flush wins and counts one bubble. The killed instruction does not reload unless upstream re-presents it.
- flush together with stall_ext: the flush wins.
- stall_ext with hazard_stall: the stage holds and hazard_stall stays asserted. No bubble is counted.

## Test plan
- Reset: drive inputs nonzero and pulse reset_n low between edges -> all outputs 0 immediately, hazard_stall=0, bubble_count=0.
- Plain load: in_valid=1, readData1=0x1234, rd=7, regWrite=1, aluOp=2 -> next edge out_readData1=0x1234, out_rd=7, out_regWrite=1, out_aluOp=2, out_valid=1.
- Load-use: lw with rt=5, memRead=1 latched, then decode presents rs=5 -> hazard_stall=1. Next edge out_valid=0, controls 0, bubble_count=1. Next edge the dependent instruction loads with out_valid=1.
- Register-zero: latched lw rt=0 and decode rs=0 -> hazard_stall=0, no bubble.
- Flush/stall priority:
  - flush=1 and stall_ext=1 with valid input -> out_valid=0, out_memWrite=0, bubble_count+1.
  - stall_ext alone for 3 cycles -> all outputs unchanged.
- Saturation: CNT_W=2, force 5 hazard bubbles -> bubble_count stops at 3.
